// File: rtl/modulo_controlador_contador_7_bits_if.sv
// Command/status and counter-drive bundle between the run sequencer and its environment.
// The master side issues run commands and closes the loop with the counter's q.
interface modulo_controlador_contador_7_bits_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic       mode_up;
  logic [6:0] start_val;
  logic [6:0] end_val;
  logic [6:0] cnt_q;
  logic       cnt_load;
  logic [6:0] cnt_e_load;
  logic       cnt_up_down;
  logic       cnt_enable;
  logic       busy;
  logic       done;
  logic [2:0] state;

  modport master (
    output start, pause, abort, mode_up, start_val, end_val, cnt_q,
    input  cnt_load, cnt_e_load, cnt_up_down, cnt_enable, busy, done, state
  );

  modport slave (
    input  start, pause, abort, mode_up, start_val, end_val, cnt_q,
    output cnt_load, cnt_e_load, cnt_up_down, cnt_enable, busy, done, state
  );
endinterface

// File: rtl/modulo_controlador_contador_7_bits.sv
// Run sequencer for a 7-bit up/down counter with parallel load: loads a start value,
// enables counting until q reaches the end value, with pause, abort and optional auto-reload.
module modulo_controlador_contador_7_bits #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic                                 clk,
  input logic                                 clr,
  modulo_controlador_contador_7_bits_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCount = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] start_val_q, start_val_d;
  logic [6:0] end_val_q, end_val_d;
  logic       mode_up_q, mode_up_d;
  logic       at_end;

  assign at_end = (bus.cnt_q == end_val_q);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      start_val_q <= '0;
      end_val_q   <= '0;
      mode_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_val_q <= start_val_d;
      end_val_q   <= end_val_d;
      mode_up_q   <= mode_up_d;
    end
  end

  // Abort beats pause, pause beats the normal transition; the command is latched only in idle.
  always_comb begin
    state_d     = state_q;
    start_val_d = start_val_q;
    end_val_d   = end_val_q;
    mode_up_d   = mode_up_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          start_val_d = bus.start_val;
          end_val_d   = bus.end_val;
          mode_up_d   = bus.mode_up;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        state_d = bus.abort ? StIdle : StCount;
      end
      StCount: begin
        if (bus.abort)      state_d = StIdle;
        else if (bus.pause) state_d = StPause;
        else if (at_end)    state_d = StDone;
      end
      StPause: begin
        if (bus.abort)       state_d = StIdle;
        else if (!bus.pause) state_d = StCount;
      end
      StDone: begin
        if (bus.abort)        state_d = StIdle;
        else if (AUTO_RELOAD) state_d = StLoad;
        else                  state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cnt_load    = (state_q == StLoad);
    bus.cnt_e_load  = start_val_q;
    bus.cnt_up_down = mode_up_q;
    // Gated combinationally so the counter never steps past the end value.
    bus.cnt_enable  = (state_q == StCount) && !at_end && !bus.pause && !bus.abort;
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.state       = state_q;
  end

endmodule

// File: tb/tb_modulo_controlador_contador_7_bits.sv
// Directed bench: two sequencers (single-shot and auto-reload) each closing the loop
// through a behavioural 7-bit up/down counter with parallel load.
module tb_modulo_controlador_contador_7_bits;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  modulo_controlador_contador_7_bits_if bus0 ();
  modulo_controlador_contador_7_bits_if bus1 ();

  modulo_controlador_contador_7_bits #(.AUTO_RELOAD(1'b0)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus0)
  );

  modulo_controlador_contador_7_bits #(.AUTO_RELOAD(1'b1)) u_dut_ar (
    .clk (clk),
    .clr (clr),
    .bus (bus1)
  );

  // External counter: not touched by clr.
  logic [6:0] q0 = '0;
  logic [6:0] q1 = '0;
  always @(posedge clk) begin
    if (bus0.cnt_load)        q0 <= bus0.cnt_e_load;
    else if (bus0.cnt_enable) q0 <= bus0.cnt_up_down ? q0 + 7'd1 : q0 - 7'd1;
    if (bus1.cnt_load)        q1 <= bus1.cnt_e_load;
    else if (bus1.cnt_enable) q1 <= bus1.cnt_up_down ? q1 + 7'd1 : q1 - 7'd1;
  end
  assign bus0.cnt_q = q0;
  assign bus1.cnt_q = q1;

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run0(input logic [6:0] sv, input logic [6:0] ev, input logic up);
    bus0.start = 1'b1; bus0.start_val = sv; bus0.end_val = ev; bus0.mode_up = up;
    nxt();
    bus0.start = 1'b0; bus0.start_val = '0; bus0.end_val = '0; bus0.mode_up = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus0.start = 1'b1; bus0.start_val = 7'd55; bus0.end_val = 7'd66; bus0.mode_up = 1'b1;
    bus1.start = 1'b1; bus1.start_val = 7'd12; bus1.end_val = 7'd13; bus1.mode_up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nxt();
      #1;
      total++;
      if ({bus0.state, bus0.busy, bus0.done, bus0.cnt_load, bus0.cnt_enable} !== 7'b0) begin
        bad++;
        $display("FAIL reset_ctrl%0d got st=%0d busy=%b done=%b ld=%b en=%b want all 0", i,
                 bus0.state, bus0.busy, bus0.done, bus0.cnt_load, bus0.cnt_enable);
      end
      total++;
      if ({bus0.cnt_e_load, bus0.cnt_up_down} !== 8'h00) begin
        bad++;
        $display("FAIL reset_data%0d got e_load=%0d up_down=%b want 0 0", i,
                 bus0.cnt_e_load, bus0.cnt_up_down);
      end
      total++;
      if ({bus1.state, bus1.busy, bus1.cnt_e_load} !== 11'b0) begin
        bad++;
        $display("FAIL reset_ar%0d got st=%0d busy=%b e_load=%0d want 0", i,
                 bus1.state, bus1.busy, bus1.cnt_e_load);
      end
    end
    clr = 1'b0;
    bus0.start = 1'b0; bus0.start_val = '0; bus0.end_val = '0; bus0.mode_up = 1'b0;
    bus1.start = 1'b0; bus1.start_val = '0; bus1.end_val = '0; bus1.mode_up = 1'b0;
    nxt();
  endtask

  // 10 -> 15 up: LOAD at t+1, q 10..15 over t+2..t+7, done at t+8; a start at t+4 is ignored.
  task automatic test_count_up();
    start_run0(7'd10, 7'd15, 1'b1);
    #1;
    total++;
    if ({bus0.state, bus0.cnt_load, bus0.busy, bus0.cnt_enable} !== {3'd1, 3'b110}) begin
      bad++;
      $display("FAIL up_load got st=%0d ld=%b busy=%b en=%b want 1 1 1 0",
               bus0.state, bus0.cnt_load, bus0.busy, bus0.cnt_enable);
    end
    for (int k = 2; k <= 8; k++) begin
      nxt();
      if (k == 4) begin
        bus0.start = 1'b1; bus0.start_val = 7'd99; bus0.end_val = 7'd100;
      end else begin
        bus0.start = 1'b0; bus0.start_val = '0; bus0.end_val = '0;
      end
      #1;
      total++;
      if (k < 8 && {bus0.state, bus0.cnt_q, bus0.done, bus0.cnt_load, bus0.busy}
          !== {3'd2, 7'(10 + k - 2), 3'b001}) begin
        bad++;
        $display("FAIL up_count t+%0d got st=%0d q=%0d done=%b ld=%b want 2 %0d 0 0", k,
                 bus0.state, bus0.cnt_q, bus0.done, bus0.cnt_load, 10 + k - 2);
      end
      if (k == 8 && {bus0.state, bus0.cnt_q, bus0.done, bus0.busy, bus0.cnt_enable}
          !== {3'd4, 7'd15, 3'b110}) begin
        bad++;
        $display("FAIL up_done t+8 got st=%0d q=%0d done=%b busy=%b en=%b want 4 15 1 1 0",
                 bus0.state, bus0.cnt_q, bus0.done, bus0.busy, bus0.cnt_enable);
      end
    end
    total++;
    if (bus0.cnt_e_load !== 7'd10) begin
      bad++;
      $display("FAIL up_no_relatch got e_load=%0d want 10", bus0.cnt_e_load);
    end
    nxt();
    #1;
    total++;
    if ({bus0.state, bus0.busy, bus0.done, bus0.cnt_q} !== {3'd0, 2'b00, 7'd15}) begin
      bad++;
      $display("FAIL up_idle got st=%0d busy=%b done=%b q=%0d want 0 0 0 15",
               bus0.state, bus0.busy, bus0.done, bus0.cnt_q);
    end
  endtask

  // 3 -> 125 down wraps through 0: N=6, done at t+9.
  task automatic test_down_wrap();
    logic [6:0] exp_q [7];
    exp_q = '{7'd3, 7'd2, 7'd1, 7'd0, 7'd127, 7'd126, 7'd125};
    start_run0(7'd3, 7'd125, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      nxt();
      #1;
      total++;
      if (k < 9 && {bus0.state, bus0.cnt_q, bus0.done} !== {3'd2, exp_q[k-2], 1'b0}) begin
        bad++;
        $display("FAIL down_count t+%0d got st=%0d q=%0d done=%b want 2 %0d 0", k,
                 bus0.state, bus0.cnt_q, bus0.done, exp_q[k-2]);
      end
      if (k == 9 && {bus0.state, bus0.cnt_q, bus0.done} !== {3'd4, 7'd125, 1'b1}) begin
        bad++;
        $display("FAIL down_done t+9 got st=%0d q=%0d done=%b want 4 125 1",
                 bus0.state, bus0.cnt_q, bus0.done);
      end
    end
    nxt();
    nxt();
    #1;
    total++;
    if ({bus0.state, bus0.cnt_q} !== {3'd0, 7'd125}) begin
      bad++;
      $display("FAIL down_hold got st=%0d q=%0d want 0 125", bus0.state, bus0.cnt_q);
    end
  endtask

  // start == end: LOAD, COUNT, DONE with no enable pulse.
  task automatic test_equal();
    logic [2:0] exp_st [3];
    exp_st = '{3'd1, 3'd2, 3'd4};
    start_run0(7'd40, 7'd40, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) nxt();
      #1;
      total++;
      if ({bus0.state, bus0.cnt_enable, bus0.done} !== {exp_st[k-1], 1'b0, k == 3}) begin
        bad++;
        $display("FAIL equal t+%0d got st=%0d en=%b done=%b want %0d 0 %b", k,
                 bus0.state, bus0.cnt_enable, bus0.done, exp_st[k-1], k == 3);
      end
    end
    total++;
    if (bus0.cnt_q !== 7'd40) begin
      bad++;
      $display("FAIL equal_q got q=%0d want 40", bus0.cnt_q);
    end
    nxt();
  endtask

  // 0 -> 20 up, pause high for t+9..t+12 at q=7; PAUSE->COUNT takes one more cycle, done at t+28.
  task automatic test_pause();
    start_run0(7'd0, 7'd20, 1'b1);
    for (int k = 2; k <= 9; k++) nxt();
    bus0.pause = 1'b1;
    #1;
    total++;
    if ({bus0.state, bus0.cnt_q, bus0.cnt_enable} !== {3'd2, 7'd7, 1'b0}) begin
      bad++;
      $display("FAIL pause_gate t+9 got st=%0d q=%0d en=%b want 2 7 0",
               bus0.state, bus0.cnt_q, bus0.cnt_enable);
    end
    for (int k = 10; k <= 13; k++) begin
      nxt();
      if (k == 13) bus0.pause = 1'b0;
      #1;
      total++;
      if ({bus0.state, bus0.cnt_q, bus0.cnt_enable, bus0.busy} !== {3'd3, 7'd7, 2'b01}) begin
        bad++;
        $display("FAIL pause_hold t+%0d got st=%0d q=%0d en=%b busy=%b want 3 7 0 1", k,
                 bus0.state, bus0.cnt_q, bus0.cnt_enable, bus0.busy);
      end
    end
    nxt();
    #1;
    total++;
    if ({bus0.state, bus0.cnt_q, bus0.cnt_enable} !== {3'd2, 7'd7, 1'b1}) begin
      bad++;
      $display("FAIL pause_resume t+14 got st=%0d q=%0d en=%b want 2 7 1",
               bus0.state, bus0.cnt_q, bus0.cnt_enable);
    end
    for (int k = 15; k <= 28; k++) begin
      nxt();
      #1;
      if (k >= 27) begin
        total++;
        if ({bus0.done, bus0.cnt_q} !== {k == 28, 7'd20}) begin
          bad++;
          $display("FAIL pause_done t+%0d got done=%b q=%0d want %b 20", k,
                   bus0.done, bus0.cnt_q, k == 28);
        end
      end
    end
    nxt();
  endtask

  // Abort at q=9 (t+11) of 0 -> 50: idle next edge, no done, q frozen.
  task automatic test_abort();
    start_run0(7'd0, 7'd50, 1'b1);
    for (int k = 2; k <= 11; k++) nxt();
    bus0.abort = 1'b1;
    #1;
    total++;
    if ({bus0.cnt_q, bus0.cnt_enable} !== {7'd9, 1'b0}) begin
      bad++;
      $display("FAIL abort_gate got q=%0d en=%b want 9 0", bus0.cnt_q, bus0.cnt_enable);
    end
    for (int k = 12; k <= 13; k++) begin
      nxt();
      bus0.abort = 1'b0;
      #1;
      total++;
      if ({bus0.state, bus0.busy, bus0.done, bus0.cnt_q} !== {3'd0, 2'b00, 7'd9}) begin
        bad++;
        $display("FAIL abort_idle t+%0d got st=%0d busy=%b done=%b q=%0d want 0 0 0 9", k,
                 bus0.state, bus0.busy, bus0.done, bus0.cnt_q);
      end
    end
  endtask

  // clr at t+5 of 0 -> 50 (q=3, still enabled that edge): outputs drop, counter keeps q=4.
  task automatic test_reset_mid_run();
    start_run0(7'd0, 7'd50, 1'b1);
    for (int k = 2; k <= 5; k++) nxt();
    clr = 1'b1;
    nxt();
    clr = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      #1;
      total++;
      if ({bus0.state, bus0.busy, bus0.cnt_e_load, bus0.cnt_up_down, bus0.cnt_q}
          !== {3'd0, 1'b0, 7'd0, 1'b0, 7'd4}) begin
        bad++;
        $display("FAIL clr_mid t+%0d got st=%0d busy=%b e_load=%0d ud=%b q=%0d want 0 0 0 0 4",
                 k, bus0.state, bus0.busy, bus0.cnt_e_load, bus0.cnt_up_down, bus0.cnt_q);
      end
      nxt();
    end
  endtask

  // Auto-reload 0 -> 2: done at t+5, t+10; reload at t+6, t+11.
  task automatic test_auto_reload();
    int seen_wrong = 0;
    bus1.start = 1'b1; bus1.start_val = 7'd0; bus1.end_val = 7'd2; bus1.mode_up = 1'b1;
    nxt();
    bus1.start = 1'b0; bus1.start_val = '0; bus1.end_val = '0; bus1.mode_up = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) nxt();
      #1;
      total++;
      if ({bus1.done, bus1.cnt_load} !== {(k == 5 || k == 10), (k % 5 == 1)}) begin
        bad++;
        $display("FAIL reload t+%0d got done=%b ld=%b want %b %b", k, bus1.done,
                 bus1.cnt_load, (k == 5 || k == 10), (k % 5 == 1));
      end
    end
    bus1.abort = 1'b1;
    nxt();
    bus1.abort = 1'b0;
    #1;
    total++;
    if ({bus1.state, bus1.busy} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reload_abort got st=%0d busy=%b want 0 0", bus1.state, bus1.busy);
    end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.pause = 1'b0; bus0.abort = 1'b0; bus0.mode_up = 1'b0;
    bus0.start_val = '0; bus0.end_val = '0;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.abort = 1'b0; bus1.mode_up = 1'b0;
    bus1.start_val = '0; bus1.end_val = '0;
    nxt();
    test_reset();
    test_count_up();
    test_down_wrap();
    test_equal();
    test_pause();
    test_abort();
    test_reset_mid_run();
    test_auto_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
